// File: rtl/div_pkg.sv
// Shared types and constants for the divide issue sequencer and its request FIFO.
package div_pkg;

    localparam int unsigned DIV_W = 32;
    localparam logic [DIV_W-1:0] DIV_INF = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        TOUT,
        RESULT,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [DIV_W-1:0] a;
        logic [DIV_W-1:0] b;
        logic             sign;
    } div_op_t;

    function automatic logic is_zero(input logic [DIV_W-1:0] v);
        return v == '0;
    endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO holding divide operands and tags; in-ready is registered from the next occupancy.
module div_req_fifo
    import div_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  div_op_t                i_op,
    input  logic [TAG_W-1:0]       i_tag,
    output div_op_t                o_op,
    output logic [TAG_W-1:0]       o_tag,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    div_op_t            r_op_mem  [DEPTH];
    logic [TAG_W-1:0]   r_tag_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_ready;

    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_nxt;

    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_ready     = r_ready;
    assign o_op        = r_op_mem[r_rd_ptr];
    assign o_tag       = r_tag_mem[r_rd_ptr];

    assign w_push      = i_push && !o_full;
    assign w_pop       = i_pop && !o_empty;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Storage needs no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wr_ptr]  <= i_op;
            r_tag_mem[r_wr_ptr] <= i_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            // A pop out of a full FIFO only raises ready on the following cycle.
            r_ready <= (w_count_nxt != CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/div_issue_sequencer.sv
// Issues buffered divide requests to an iterative divider one at a time and returns tagged
// results with backpressure, flagging divide-by-zero and divider timeouts.
module div_issue_sequencer
    import div_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIV_W-1:0] in_a,
    input  logic [DIV_W-1:0] in_b,
    input  logic             in_sign,
    input  logic [TAG_W-1:0] in_tag,
    output logic             div_start,
    output logic [DIV_W-1:0] div_a,
    output logic [DIV_W-1:0] div_b,
    output logic             div_sign,
    input  logic             div_ready,
    input  logic [DIV_W-1:0] div_quotient,
    input  logic [DIV_W-1:0] div_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DIV_W-1:0] out_quotient,
    output logic [DIV_W-1:0] out_remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dbz,
    output logic             out_timeout,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TOUT_VAL = CNT_W'(TIMEOUT_CYC);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_div_start;
    div_op_t                r_div_op;
    logic [TAG_W-1:0]       r_tag;
    logic                   r_dbz;
    logic                   r_out_valid;
    logic [DIV_W-1:0]       r_out_q;
    logic [DIV_W-1:0]       r_out_r;
    logic [TAG_W-1:0]       r_out_tag;
    logic                   r_out_dbz;
    logic                   r_out_timeout;

    div_op_t                w_in_op;
    div_op_t                w_head_op;
    logic [TAG_W-1:0]       w_head_tag;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [$clog2(DEPTH):0] w_fifo_count;
    logic                   w_fifo_ready;
    logic                   w_push;
    logic                   w_pop;
    logic [CNT_W-1:0]       w_cnt_inc;

    assign w_in_op   = '{a: in_a, b: in_b, sign: in_sign};
    assign w_push    = in_valid && w_fifo_ready && !w_fifo_full;
    assign w_pop     = (r_state == IDLE) && !w_fifo_empty && div_ready;
    assign w_cnt_inc = (r_cnt == TOUT_VAL) ? r_cnt : r_cnt + CNT_W'(1);

    div_req_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_op    (w_in_op),
        .i_tag   (in_tag),
        .o_op    (w_head_op),
        .o_tag   (w_head_tag),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count),
        .o_ready (w_fifo_ready)
    );

    // Sequencer FSM with registered divider and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_div_start   <= 1'b0;
            r_div_op      <= '0;
            r_tag         <= '0;
            r_dbz         <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_q       <= '0;
            r_out_r       <= '0;
            r_out_tag     <= '0;
            r_out_dbz     <= 1'b0;
            r_out_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_div_op    <= w_head_op;
                        r_tag       <= w_head_tag;
                        r_dbz       <= is_zero(w_head_op.b);
                        r_cnt       <= '0;
                        r_div_start <= 1'b1;
                        r_state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_cnt <= w_cnt_inc;
                    if (!div_ready) begin
                        r_div_start <= 1'b0;
                        r_state     <= WAIT;
                    end else if (r_cnt == TOUT_VAL) begin
                        r_div_start <= 1'b0;
                        r_state     <= TOUT;
                    end
                end
                WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (div_ready) begin
                        r_out_valid   <= 1'b1;
                        r_out_q       <= div_quotient;
                        r_out_r       <= div_remainder;
                        r_out_tag     <= r_tag;
                        r_out_dbz     <= r_dbz;
                        r_out_timeout <= 1'b0;
                        r_state       <= RESULT;
                    end else if (r_cnt == TOUT_VAL) begin
                        r_state <= TOUT;
                    end
                end
                TOUT: begin
                    r_out_valid   <= 1'b1;
                    r_out_q       <= '0;
                    r_out_r       <= '0;
                    r_out_tag     <= r_tag;
                    r_out_dbz     <= r_dbz;
                    r_out_timeout <= 1'b1;
                    r_state       <= RESULT;
                end
                RESULT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A divider that outlived its timeout must finish before the next launch.
                    if (div_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready      = w_fifo_ready;
    assign div_start     = r_div_start;
    assign div_a         = r_div_op.a;
    assign div_b         = r_div_op.b;
    assign div_sign      = r_div_op.sign;
    assign out_valid     = r_out_valid;
    assign out_quotient  = r_out_q;
    assign out_remainder = r_out_r;
    assign out_tag       = r_out_tag;
    assign out_dbz       = r_out_dbz;
    assign out_timeout   = r_out_timeout;
    assign busy          = (r_state != IDLE) || (w_fifo_count != '0);

endmodule

// File: tb/tb_div_issue_sequencer.sv
// Scoreboard bench for div_issue_sequencer with a behavioural iterative divider model.
module tb_div_issue_sequencer;
    import div_pkg::*;

    localparam int unsigned DEPTH       = 4;
    localparam int unsigned TAG_W       = 4;
    localparam int unsigned TIMEOUT_CYC = 128;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = '0;
    logic [31:0]      in_b = '0;
    logic             in_sign = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             div_start;
    logic [31:0]      div_a, div_b;
    logic             div_sign;
    logic             dv_ready = 1'b1;
    logic [31:0]      dv_q = '0;
    logic [31:0]      dv_r = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_quotient, out_remainder;
    logic [TAG_W-1:0] out_tag;
    logic             out_dbz, out_timeout, busy;

    typedef struct {
        logic [31:0]      q;
        logic [31:0]      r;
        logic [TAG_W-1:0] tag;
        logic             dbz;
        logic             tmo;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   res_cnt = 0;
    int   pushed = 0;
    int   rdy_mode = 0;
    bit   dv_stuck = 1'b0;
    int   dv_lat_lo = 1;
    int   dv_lat_hi = 4;
    int   dv_cnt = 0;

    div_issue_sequencer #(
        .DEPTH       (DEPTH),
        .TAG_W       (TAG_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_sign       (in_sign),
        .in_tag        (in_tag),
        .div_start     (div_start),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_sign      (div_sign),
        .div_ready     (dv_ready),
        .div_quotient  (dv_q),
        .div_remainder (dv_r),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_tag       (out_tag),
        .out_dbz       (out_dbz),
        .out_timeout   (out_timeout),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain language-level division semantics.
    function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                     input logic [TAG_W-1:0] tag, input bit tmo);
        exp_t e;
        int   sa, sb;
        e.tag = tag;
        e.dbz = (b == 32'd0);
        e.tmo = tmo;
        if (b == 32'd0) begin
            e.q = DIV_INF;
            e.r = a;
        end else if (!s) begin
            e.q = a / b;
            e.r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a;
            e.r = 32'd0;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            e.q = 32'(sa / sb);
            e.r = 32'(sa % sb);
        end
        if (tmo) begin
            e.q = 32'd0;
            e.r = 32'd0;
        end
        return e;
    endfunction

    // Divider model works on magnitudes, then restores signs.
    function automatic logic [63:0] hw_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ua, ub, uq, ur;
        logic        na, nb;
        if (b == 32'd0) return {DIV_INF, a};
        na = s & a[31];
        nb = s & b[31];
        ua = na ? -a : a;
        ub = nb ? -b : b;
        uq = ua / ub;
        ur = ua % ub;
        return {(na ^ nb) ? -uq : uq, na ? -ur : ur};
    endfunction

    always @(posedge clk) begin
        if (dv_stuck) begin
            dv_ready <= 1'b1;
        end else if (dv_ready && div_start) begin
            {dv_q, dv_r} <= hw_div(div_a, div_b, div_sign);
            dv_ready     <= 1'b0;
            dv_cnt       <= $urandom_range(dv_lat_hi, dv_lat_lo);
        end else if (!dv_ready) begin
            if (dv_cnt <= 1) dv_ready <= 1'b1;
            else dv_cnt <= dv_cnt - 1;
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            res_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got tag %0d expected none", out_tag);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_quotient", out_quotient, mon_e.q);
                chk("out_remainder", out_remainder, mon_e.r);
                chk("out_tag", 32'(out_tag), 32'(mon_e.tag));
                chk("out_dbz", 32'(out_dbz), 32'(mon_e.dbz));
                chk("out_timeout", 32'(out_timeout), 32'(mon_e.tmo));
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [TAG_W-1:0] tag, input bit tmo);
        int waitc = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sign  = s;
        in_tag   = tag;
        @(negedge clk);
        while (!in_ready && waitc < 1000) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 for tag %0d", tag);
        end else begin
            exp_q.push_back(ref_div(a, b, s, tag, tmo));
            pushed++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || busy) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending busy=%0d expected 0 pending idle",
                     exp_q.size(), busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < budget);
    endtask

    initial begin
        int lat;
        int base;
        logic [31:0] rb;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_div_start", 32'(div_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_quotient", out_quotient, 32'd0);
        chk("rst_div_a", div_a, 32'd0);
        chk("rst_out_timeout", 32'(out_timeout), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic, divide-by-zero and signed results
        send(32'd100, 32'd7, 1'b0, 4'd3, 1'b0);
        wait_drain(200);
        send(32'h1234, 32'd0, 1'b0, 4'd1, 1'b0);
        wait_drain(200);
        send(-32'd100, 32'd7, 1'b1, 4'd2, 1'b0);
        wait_drain(200);

        // Backpressure: one result held, FIFO fills with four more
        rdy_mode = 1;
        base = res_cnt;
        send(32'd500, 32'd3, 1'b0, 4'd0, 1'b0);
        wait_out_valid(200, lat);
        chk("hold_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_a     = 32'(1000 * i + 7);
            in_b     = 32'(i + 2);
            in_sign  = 1'b0;
            in_tag   = TAG_W'(i);
            @(negedge clk);
            chk("burst_in_ready", 32'(in_ready), 32'd1);
            exp_q.push_back(ref_div(in_a, in_b, 1'b0, in_tag, 1'b0));
            pushed++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_tag", 32'(out_tag), 32'd0);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        wait_drain(400);
        chk("burst_results", 32'(res_cnt - base), 32'd5);

        // Divider never drops ready: forced timeout result, then normal operation
        dv_stuck = 1'b1;
        send(32'd50, 32'd9, 1'b0, 4'd5, 1'b1);
        wait_out_valid(400, lat);
        checks++;
        if (lat < int'(TIMEOUT_CYC) || lat > int'(TIMEOUT_CYC) + 8) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d",
                     lat, TIMEOUT_CYC, TIMEOUT_CYC + 8);
        end
        wait_drain(50);
        dv_stuck = 1'b0;
        send(32'd1000, 32'd10, 1'b0, 4'd6, 1'b0);
        wait_drain(200);

        // Reset while waiting on a slow divider
        dv_lat_lo = 30;
        dv_lat_hi = 30;
        send(32'd77, 32'd5, 1'b0, 4'd7, 1'b0);
        lat = 0;
        while (!div_start && lat < 50) begin @(negedge clk); lat++; end
        while (div_start && lat < 100) begin @(negedge clk); lat++; end
        chk("wait_reached_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        exp_q.delete();
        pushed--;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_div_start", 32'(div_start), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        dv_lat_lo = 1;
        dv_lat_hi = 8;
        send(32'd200, 32'd9, 1'b0, 4'd8, 1'b0);
        wait_drain(300);

        // Random requests with random consumer stalls
        rdy_mode = 2;
        for (int i = 0; i < 20; i++) begin
            rb = (i % 2 == 1) ? $urandom : ($urandom & 32'd3);
            send($urandom, rb, 1'($urandom_range(0, 1)), TAG_W'(i), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_drain(3000);
        rdy_mode = 0;

        chk("total_results", 32'(res_cnt), 32'(pushed));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
